fifo_read_arbiter: RTL and testbench

- Round-robin read scheduler that shares one egress stream between NUM_REQUESTERS asynchronous FIFOs, all read in the egress clock domain.
- Issues per-FIFO read enables and tracks read latency with an ID tag pipeline.
- Buffers returned words in a credit-protected output buffer so downstream backpressure never drops data.
- Sits between the per-ingress-port FIFOs and the switch egress datapath. Non-FWFT FIFO mode only.

---
 rtl/fifo_read_arbiter_pkg.sv | 36 +++
 rtl/fifo_read_arbiter_buffer.sv | 50 +++++
 rtl/fifo_read_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_read_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_read_arbiter_pkg.sv
// Shared FSM encodings, ID sizing and the round-robin selector for the FIFO read arbiter.
package fifo_read_arbiter_package;

  typedef logic [1:0] state_t;
  localparam state_t STOPPED  = 2'd0;
  localparam state_t RUNNING  = 2'd1;
  localparam state_t DRAINING = 2'd2;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } grant_t;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Lowest-index set bit of mask at or after ptr, wrapping modulo n (n <= 16).
  function automatic grant_t rr_select(input logic [15:0] mask, input logic [3:0] ptr, input int n);
    grant_t     g;
    logic [5:0] j;
    g = '0;
    for (int k = 15; k >= 0; k--) begin
      if (k < n) begin
        j = {2'b00, ptr} + 6'(k);
        if (j >= 6'(n)) j = j - 6'(n);
        if (mask[j[3:0]]) begin
          g.found = 1'b1;
          g.idx   = j[3:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_buffer.sv
// Circular buffer with a registered head word; push and pop in the same cycle keep occupancy.
// Caller guarantees no push when full and no pop when empty.
module fifo_read_arbiter_buffer #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;

  always_comb begin
    wr_d = wr_q + (AW+1)'(push_i);
    rd_d = rd_q + (AW+1)'(pop_i);
    // The new head is the word being written when the buffer is (or becomes) empty.
    if (push_i && (rd_d == wr_q)) head_d = push_dat_i;
    else                          head_d = mem_q[rd_d[AW-1:0]];
  end

  always_ff @(posedge clock_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  assign head_dat_o  = head_q;
  assign occupancy_o = wr_q - rd_q;

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin reader of NUM_REQUESTERS non-FWFT FIFOs into one stream; first word out READ_LATENCY+1
// cycles after issue; reads are issued only against free buffer credits, so output_ready backpressure never drops data.
module fifo_read_arbiter
  import fifo_read_arbiter_package::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int READ_LATENCY   = 1,
  parameter int BUFFER_DEPTH   = 4
) (
  input  logic                                   clock_i,
  input  logic                                   reset_n_i,
  input  logic                                   enable_i,
  input  logic [NUM_REQUESTERS-1:0]              requester_mask_i,
  input  logic [NUM_REQUESTERS-1:0]              fifo_empty_i,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   fifo_read_data_i,
  input  logic [NUM_REQUESTERS-1:0]              fifo_read_data_valid_i,
  output logic [NUM_REQUESTERS-1:0]              fifo_read_enable_o,
  output logic [DATA_WIDTH-1:0]                  output_data_o,
  output logic [id_width(NUM_REQUESTERS)-1:0]    output_id_o,
  output logic                                   output_valid_o,
  input  logic                                   output_ready_i,
  output logic                                   idle_o,
  output logic                                   protocol_error_o
);

  localparam int IDW = id_width(NUM_REQUESTERS);
  localparam int AW  = $clog2(BUFFER_DEPTH);
  localparam int BW  = DATA_WIDTH + IDW;
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(BUFFER_DEPTH);

  state_t                          state_q, state_d;
  logic [IDW-1:0]                  ptr_q, ptr_d;
  logic [READ_LATENCY-1:0]         tag_vld_q, tag_vld_d;
  logic [READ_LATENCY-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic                            perr_q, perr_d;

  logic [NUM_REQUESTERS-1:0] eligible;
  grant_t                    sel;
  logic [IDW-1:0]            gnt_idx;
  logic                      issue;
  logic [AW+1:0]             inflight;
  logic [AW:0]               occupancy;
  logic                      ret_vld;
  logic [IDW-1:0]            ret_id;
  logic [DATA_WIDTH-1:0]     ret_dat;
  logic [NUM_REQUESTERS-1:0] exp_vld;
  logic [BW-1:0]             head_dat;
  logic                      pop;

  assign eligible = requester_mask_i & ~fifo_empty_i;
  assign sel      = rr_select(16'(eligible), 4'(ptr_q), NUM_REQUESTERS);
  assign gnt_idx  = IDW'(sel.idx);

  always_comb begin
    inflight = '0;
    for (int s = 0; s < READ_LATENCY; s++) inflight = inflight + (AW+2)'(tag_vld_q[s]);
  end

  // Occupancy is the registered value, so a pop this cycle frees its credit only next cycle.
  assign issue = (state_q == RUNNING) && sel.found && (({1'b0, occupancy} + inflight) < DEPTH_C);

  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) fifo_read_enable_o[i] = issue && (gnt_idx == IDW'(i));
  end

  assign ret_vld = tag_vld_q[READ_LATENCY-1];
  assign ret_id  = tag_id_q[READ_LATENCY-1];

  always_comb begin
    ret_dat = '0;
    exp_vld = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (ret_vld && (ret_id == IDW'(i))) begin
        ret_dat    = fifo_read_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        exp_vld[i] = 1'b1;
      end
    end
  end

  always_comb begin
    tag_vld_d    = tag_vld_q;
    tag_id_d     = tag_id_q;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = gnt_idx;
    for (int s = 1; s < READ_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end

    ptr_d = ptr_q;
    if (issue) ptr_d = (gnt_idx == IDW'(NUM_REQUESTERS-1)) ? '0 : gnt_idx + IDW'(1);

    // Missing data for a live tag, or any stray valid, is latched until reset.
    perr_d = perr_q
           | (|(fifo_read_data_valid_i & ~exp_vld))
           | (ret_vld && !(|(fifo_read_data_valid_i & exp_vld)));

    state_d = state_q;
    case (state_q)
      STOPPED:  if (enable_i) state_d = RUNNING;
      RUNNING:  if (!enable_i) state_d = DRAINING;
      DRAINING: begin
        if (enable_i)                                   state_d = RUNNING;
        else if ((tag_vld_q == '0) && (occupancy == '0)) state_d = STOPPED;
      end
      default:  state_d = STOPPED;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= STOPPED;
      ptr_q     <= '0;
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      perr_q    <= perr_d;
    end
  end

  assign pop = output_valid_o && output_ready_i;

  fifo_read_arbiter_buffer #(
    .WIDTH (BW),
    .DEPTH (BUFFER_DEPTH)
  ) u_buffer (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .push_i      (ret_vld),
    .push_dat_i  ({ret_id, ret_dat}),
    .pop_i       (pop),
    .head_dat_o  (head_dat),
    .occupancy_o (occupancy)
  );

  assign output_valid_o   = (occupancy != '0);
  assign output_data_o    = head_dat[DATA_WIDTH-1:0];
  assign output_id_o      = head_dat[BW-1:DATA_WIDTH];
  assign idle_o           = (state_q == STOPPED);
  assign protocol_error_o = perr_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench: queue-based FIFO and arbiter model checked every cycle, plus literal scenario checks.
module tb_fifo_read_arbiter;
  localparam int N = 4, DW = 16, L = 1, D = 4, IDW = 2;

  logic              clock_i = 1'b0;
  logic              reset_n_i;
  logic              enable_i;
  logic [N-1:0]      requester_mask_i;
  logic [N-1:0]      fifo_empty_i;
  logic [N*DW-1:0]   fifo_read_data_i;
  logic [N-1:0]      fifo_read_data_valid_i;
  logic [N-1:0]      fifo_read_enable_o;
  logic [DW-1:0]     output_data_o;
  logic [IDW-1:0]    output_id_o;
  logic              output_valid_o;
  logic              output_ready_i;
  logic              idle_o;
  logic              protocol_error_o;

  always #5 clock_i = ~clock_i;

  fifo_read_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .READ_LATENCY(L), .BUFFER_DEPTH(D)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
    .requester_mask_i(requester_mask_i), .fifo_empty_i(fifo_empty_i),
    .fifo_read_data_i(fifo_read_data_i), .fifo_read_data_valid_i(fifo_read_data_valid_i),
    .fifo_read_enable_o(fifo_read_enable_o), .output_data_o(output_data_o),
    .output_id_o(output_id_o), .output_valid_o(output_valid_o),
    .output_ready_i(output_ready_i), .idle_o(idle_o), .protocol_error_o(protocol_error_o));

  typedef logic [DW-1:0] wq_t [$];
  typedef struct { int id; logic [DW-1:0] w; int due; } ent_t;
  typedef struct { int id; logic [DW-1:0] w; } bent_t;

  int checks = 0, errors = 0, cyc = 0;
  wq_t fq [N];
  // FIFO return pipeline
  logic          ret_v [L];
  int            ret_id [L];
  logic [DW-1:0] ret_w [L];
  logic [N-1:0]  pend_rd;
  logic          pend_rst;
  bit drop_req, stray_req, dropped_now, stray_now;
  // model
  int m_state, m_ptr;
  bit m_err;
  ent_t  m_if [$];
  bent_t m_buf [$];
  // observations
  int    ob_gnt [$];
  int    ob_gnt_cyc [$];
  bent_t ob_out [$];
  int    first_issue, first_valid, first_pop, last_pop, first_idle;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic clear_obs();
    ob_gnt.delete(); ob_gnt_cyc.delete(); ob_out.delete();
    first_issue = -1; first_valid = -1; first_pop = -1; last_pop = -1; first_idle = -1;
  endtask

  task automatic model_step();
    logic [N-1:0] elig;
    int g;
    bent_t b;
    elig = requester_mask_i & ~fifo_empty_i;
    g = -1;
    if (m_state == 1 && (m_buf.size() + m_if.size()) < D)
      for (int k = 0; k < N; k++)
        if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;

    chk("read_enable", fifo_read_enable_o, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("output_valid", output_valid_o, m_buf.size() != 0);
    chk("idle", idle_o, m_state == 0);
    chk("protocol_error", protocol_error_o, m_err);
    if (m_buf.size() != 0) begin
      chk("output_data", output_data_o, m_buf[0].w);
      chk("output_id", output_id_o, m_buf[0].id);
    end

    if (fifo_read_enable_o != 0) begin
      ob_gnt.push_back(onehot_idx(fifo_read_enable_o));
      ob_gnt_cyc.push_back(cyc);
      if (first_issue < 0) first_issue = cyc;
    end
    if (output_valid_o && first_valid < 0) first_valid = cyc;
    if (idle_o && first_idle < 0) first_idle = cyc;
    if (output_valid_o && output_ready_i) begin
      b.id = output_id_o; b.w = output_data_o;
      ob_out.push_back(b);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    pend_rd  = reset_n_i ? fifo_read_enable_o : '0;
    pend_rst = reset_n_i;

    if (!reset_n_i) begin
      m_state = 0; m_ptr = 0; m_err = 0; m_if.delete(); m_buf.delete();
    end else begin
      bit quiet;
      quiet = (m_if.size() == 0) && (m_buf.size() == 0);
      if (m_buf.size() != 0 && output_ready_i) void'(m_buf.pop_front());
      while (m_if.size() != 0 && m_if[0].due == cyc) begin
        ent_t e;
        e = m_if.pop_front();
        b.id = e.id; b.w = e.w;
        m_buf.push_back(b);
        if (dropped_now) m_err = 1;
      end
      if (stray_now) m_err = 1;
      if (g >= 0) begin
        ent_t e;
        e.id = g; e.w = fq[g][0]; e.due = cyc + L;
        m_if.push_back(e);
        m_ptr = (g + 1) % N;
      end
      case (m_state)
        0: if (enable_i) m_state = 1;
        1: if (!enable_i) m_state = 2;
        default: if (enable_i) m_state = 1; else if (quiet) m_state = 0;
      endcase
    end
    cyc++;
  endtask

  task automatic apply_fifo();
    int idx;
    dropped_now = 0; stray_now = 0;
    for (int s = L-1; s > 0; s--) begin
      ret_v[s] = ret_v[s-1]; ret_id[s] = ret_id[s-1]; ret_w[s] = ret_w[s-1];
    end
    ret_v[0] = 1'b0;
    idx = onehot_idx(pend_rd);
    if (idx >= 0 && fq[idx].size() != 0) begin
      ret_v[0] = 1'b1; ret_id[0] = idx; ret_w[0] = fq[idx].pop_front();
    end
    if (!pend_rst) for (int s = 0; s < L; s++) ret_v[s] = 1'b0;
    fifo_read_data_i       = {$urandom(), $urandom()};
    fifo_read_data_valid_i = '0;
    if (ret_v[L-1]) begin
      fifo_read_data_i[ret_id[L-1]*DW +: DW] = ret_w[L-1];
      if (drop_req && ret_id[L-1] == 2) begin
        dropped_now = 1; drop_req = 0;
      end else fifo_read_data_valid_i[ret_id[L-1]] = 1'b1;
    end
    if (stray_req) begin
      fifo_read_data_valid_i[ret_v[L-1] ? (ret_id[L-1] + 1) % N : 3] = 1'b1;
      stray_now = 1; stray_req = 0;
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < N; i++) fifo_empty_i[i] = (fq[i].size() == 0);
    @(negedge clock_i);
    model_step();
    @(posedge clock_i);
    #1;
    apply_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_reset();
    reset_n_i = 1'b0;
    cycle();
    reset_n_i = 1'b1;
  endtask

  initial begin
    reset_n_i = 1'b0; enable_i = 1'b0; requester_mask_i = '0; fifo_empty_i = '1;
    fifo_read_data_i = '0; fifo_read_data_valid_i = '0; output_ready_i = 1'b1;
    for (int s = 0; s < L; s++) begin ret_v[s] = 1'b0; ret_id[s] = 0; ret_w[s] = '0; end
    drop_req = 0; stray_req = 0; dropped_now = 0; stray_now = 0;
    m_state = 0; m_ptr = 0; m_err = 0;
    clear_obs();
    run(2);
    reset_n_i = 1'b1;
    chk("reset_idle", idle_o, 1);
    chk("reset_valid", output_valid_o, 0);
    chk("reset_data", output_data_o, 0);
    chk("reset_id", output_id_o, 0);
    chk("reset_rden", fifo_read_enable_o, 0);
    chk("reset_perr", protocol_error_o, 0);

    // single requester streaming
    for (int j = 0; j < 8; j++) fq[1].push_back(16'h0100 + 16'(j));
    requester_mask_i = 4'b0010; enable_i = 1'b1; clear_obs();
    run(16);
    chk("t1_reads", ob_gnt.size(), 8);
    if (ob_gnt.size() == 8) chk("t1_back_to_back", ob_gnt_cyc[7] - ob_gnt_cyc[0], 7);
    chk("t1_latency", first_valid - first_issue, 2);
    chk("t1_words", ob_out.size(), 8);
    foreach (ob_out[j]) begin
      chk("t1_data", ob_out[j].w, 16'h0100 + 16'(j));
      chk("t1_id", ob_out[j].id, 1);
    end

    // round robin across all four
    pulse_reset();
    for (int i = 0; i < N; i++) for (int j = 0; j < 3; j++) fq[i].push_back(16'((i << 8) | j));
    requester_mask_i = 4'hF; clear_obs();
    run(20);
    chk("t2_reads", ob_gnt.size(), 12);
    foreach (ob_gnt[j]) chk("t2_grant_order", ob_gnt[j], j % 4);
    foreach (ob_out[j]) chk("t2_out_id", ob_out[j].id, j % 4);
    chk("t2_perr", protocol_error_o, 0);

    // backpressure
    for (int i = 0; i < N; i++) for (int j = 0; j < 4; j++) fq[i].push_back(16'($urandom));
    output_ready_i = 1'b0; clear_obs();
    run(10);
    chk("t3_reads_blocked", ob_gnt.size(), D);
    chk("t3_rden_idle", fifo_read_enable_o, 0);
    output_ready_i = 1'b1;
    run(30);
    chk("t3_all_out", ob_out.size(), 16);
    if (ob_gnt_cyc.size() > D) chk("t3_resume", ob_gnt_cyc[D] - first_pop, 1);

    // drain on enable drop
    for (int j = 0; j < 10; j++) fq[0].push_back(16'h0a00 + 16'(j));
    requester_mask_i = 4'b0001; output_ready_i = 1'b0;
    run(6);
    enable_i = 1'b0; output_ready_i = 1'b1; clear_obs();
    run(10);
    chk("t4_no_reads", ob_gnt.size(), 0);
    chk("t4_words", ob_out.size(), D);
    chk("t4_idle_after_empty", first_idle - last_pop, 2);
    enable_i = 1'b1; clear_obs();
    run(12);
    chk("t4_resumed", ob_gnt.size(), 6);

    // missing data valid
    fq[2].push_back(16'hbeef); fq[2].push_back(16'hcafe);
    requester_mask_i = 4'b0100; drop_req = 1; clear_obs();
    run(8);
    chk("t5_perr_set", protocol_error_o, 1);
    chk("t5_words", ob_out.size(), 2);
    if (ob_out.size() != 0) chk("t5_word0", ob_out[0].w, 16'hbeef);
    run(3);
    chk("t5_perr_sticky", protocol_error_o, 1);
    pulse_reset();
    chk("t5_perr_cleared", protocol_error_o, 0);
    enable_i = 1'b0; stray_req = 1;
    run(3);
    chk("t5_stray_perr", protocol_error_o, 1);
    pulse_reset();

    // reset mid-stream
    enable_i = 1'b1;
    for (int i = 0; i < N; i++) for (int j = 0; j < 6; j++) fq[i].push_back(16'($urandom));
    requester_mask_i = 4'hF;
    run(5);
    reset_n_i = 1'b0;
    cycle();
    reset_n_i = 1'b1;
    chk("t6_valid", output_valid_o, 0);
    chk("t6_rden", fifo_read_enable_o, 0);
    chk("t6_idle", idle_o, 1);
    clear_obs();
    run(3);
    if (ob_gnt.size() != 0) chk("t6_ptr_zero", ob_gnt[0], 0);
    else chk("t6_ptr_zero", 64'hffff, 0);
    run(30);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int q;
        q = $urandom_range(0, N-1);
        if (fq[q].size() < 8) fq[q].push_back(16'($urandom));
      end
      if ($urandom_range(0, 15) == 0) requester_mask_i = 4'($urandom);
      output_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) enable_i = ~enable_i;
      reset_n_i = ($urandom_range(0, 700) != 0);
      cycle();
    end
    reset_n_i = 1'b1;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
